// File: rtl/pipelined_segment_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : adder_pkg
//  Description : Shared constants, the per-stage control record and a
//                parameter legality helper for the segmented pipelined adder.
//  Revision    : 1.0  initial release
// ============================================================================
package adder_pkg;

    // Operation select carried alongside each beat
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Control part of a pipeline stage record. The width-dependent data part
    // (a_rem, b_rem, sum_lo) is attached by the top level, which knows WIDTH.
    typedef struct packed {
        logic valid;   // beat present in this stage
        logic sub;     // beat is a subtraction
        logic carry;   // carry into the next segment
        logic ovf;     // signed overflow of the most recently resolved segment
    } stage_ctrl_t;

    // WIDTH must be a whole number of segments, each at least one bit wide
    function automatic logic params_ok(input int width, input int seg_w);
        return (seg_w >= 1) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/pipelined_segment_adder_segment.sv
`default_nettype none
// ============================================================================
//  Module      : adder_segment
//  Description : Combinational SEG_W-bit ripple-carry adder built from
//                full-adder cells. Also exposes the carry into its MSB so the
//                final segment can derive two's-complement overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_segment #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] i_a,
    input  logic [SEG_W-1:0] i_b,
    input  logic             i_cin,
    output logic [SEG_W-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    // Ripple the carry LSB to MSB, one full-adder cell per bit
    always_comb begin
        logic w_carry;
        w_carry = i_cin;
        o_sum   = '0;
        o_c_msb = i_cin;
        for (int i = 0; i < SEG_W; i++) begin
            if (i == SEG_W - 1) begin
                o_c_msb = w_carry;
            end
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end

endmodule : adder_segment
`default_nettype wire

// File: rtl/pipelined_segment_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_segment_adder
//  Description : Pipelined adder/subtractor on a valid/ready stream. Operands
//                are resolved SEG_W bits per stage; each segment's carry is
//                registered into the next stage. Whole-pipeline stall when the
//                output holds a beat the consumer does not take.
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_segment_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    // Falls back to a single stage on illegal parameters so elaboration can
    // reach the $error below instead of tripping over negative ranges.
    localparam int NSEG = params_ok(WIDTH, SEG_W) ? (WIDTH / SEG_W) : 1;

    if (!params_ok(WIDTH, SEG_W)) begin : g_param_err
        $error("pipelined_segment_adder: WIDTH (%0d) must be a multiple of SEG_W (%0d), SEG_W >= 1",
               WIDTH, SEG_W);
    end

    // Full stage record: control bits plus operand remainders and the sum
    // bits resolved so far. Operands travel at full width; each stage only
    // looks at its own segment.
    typedef struct packed {
        stage_ctrl_t      ctl;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_lo;
    } stage_t;

    stage_t w_entry;
    stage_t w_stg_in   [NSEG];
    stage_t w_stg_next [NSEG];
    stage_t r_stg      [NSEG];
    logic   w_adv;
    logic   w_unused_tail;

    // The pipeline moves as a unit: it may advance whenever the output slot
    // is empty or being drained this cycle.
    assign w_adv    = !r_stg[NSEG-1].ctl.valid || out_ready;
    assign in_ready = w_adv;

    // Entry: fold subtraction into an add of the inverted operand, and invert
    // the borrow-in into a carry-in, so A - B - cin = A + ~B + !cin.
    always_comb begin
        w_entry           = '0;
        w_entry.ctl.valid = in_valid;
        w_entry.ctl.sub   = in_sub;
        w_entry.ctl.carry = (in_sub == OP_SUB) ? ~in_cin : in_cin;
        w_entry.a_rem     = in_a;
        w_entry.b_rem     = (in_sub == OP_SUB) ? ~in_b : in_b;
        w_entry.sum_lo    = '0;
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [SEG_W-1:0] w_seg_sum;
        logic             w_seg_cout;
        logic             w_seg_cmsb;
        stage_t           w_nxt;

        if (k == 0) begin : g_first
            assign w_stg_in[k] = w_entry;
        end else begin : g_rest
            assign w_stg_in[k] = r_stg[k-1];
        end

        adder_segment #(
            .SEG_W (SEG_W)
        ) u_seg (
            .i_a     (w_stg_in[k].a_rem[k*SEG_W +: SEG_W]),
            .i_b     (w_stg_in[k].b_rem[k*SEG_W +: SEG_W]),
            .i_cin   (w_stg_in[k].ctl.carry),
            .o_sum   (w_seg_sum),
            .o_cout  (w_seg_cout),
            .o_c_msb (w_seg_cmsb)
        );

        // Resolve segment k: insert its sum bits, replace the carry, and
        // compute overflow (only the last stage's value reaches the output)
        always_comb begin
            w_nxt                            = w_stg_in[k];
            w_nxt.ctl.carry                  = w_seg_cout;
            w_nxt.ctl.ovf                    = w_seg_cmsb ^ w_seg_cout;
            w_nxt.sum_lo[k*SEG_W +: SEG_W]   = w_seg_sum;
        end

        assign w_stg_next[k] = w_nxt;
    end

    // Pipeline registers: cleared asynchronously, otherwise advance together
    // or hold together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                r_stg[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < NSEG; k++) begin
                r_stg[k] <= w_stg_next[k];
            end
        end
    end

    assign out_valid = r_stg[NSEG-1].ctl.valid;
    assign out_sum   = r_stg[NSEG-1].sum_lo;
    assign out_cout  = r_stg[NSEG-1].ctl.carry;
    assign out_ovf   = r_stg[NSEG-1].ctl.ovf;

    // Operand remainders and the op flag have no consumer past the last stage
    assign w_unused_tail = ^{r_stg[NSEG-1].a_rem, r_stg[NSEG-1].b_rem, r_stg[NSEG-1].ctl.sub};

endmodule : pipelined_segment_adder
`default_nettype wire

// File: tb/tb_pipelined_segment_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipelined_segment_adder
//  Description : Self-checking bench: directed vector table on the default
//                16/4 configuration, backpressure and mid-operation reset
//                sequences, plus random streams on 8/1, 8/8 and 32/8.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_segment_adder;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic rst_sw = 1'b1;
    always #5 clk = ~clk;

    int total       = 0;
    int bad         = 0;
    int sweeps_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, result packed as {ovf, cout, sum32}
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint mask, ua, ub, sa, sb, ures, sres, smax, smin;
        logic   cout, ovf;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = ua[w-1] ? ua - (longint'(1) << w) : ua;
        sb   = ub[w-1] ? ub - (longint'(1) << w) : ub;
        if (!sub) begin
            ures = ua + ub + longint'(cin);
            sres = sa + sb + longint'(cin);
            cout = ures[w];
        end else begin
            ures = ua - ub - longint'(cin);
            sres = sa - sb - longint'(cin);
            cout = (ures >= 0);
        end
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        ovf  = (sres > smax) || (sres < smin);
        return {ovf, cout, 32'(ures & mask)};
    endfunction

    // ---------------------------------------------------------------- main DUT
    logic        in_valid = 1'b0, in_ready, in_cin = 1'b0, in_sub = 1'b0;
    logic [15:0] in_a = '0, in_b = '0, out_sum;
    logic        out_valid, out_ready = 1'b1, out_cout, out_ovf;

    pipelined_segment_adder #(.WIDTH(16), .SEG_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vt [10];

    // One isolated beat: check latency (edges from accept to out_valid) and result
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        in_a      = v.a;
        in_b      = v.b;
        in_cin    = v.cin;
        in_sub    = v.sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'd4);
        chk($sformatf("vec%0d_result", idx), {out_ovf, out_cout, out_sum}, {v.ovf, v.cout, v.sum});
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_drain", idx), 64'(out_valid), 64'd0);
    endtask

    initial begin
        vt[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[6] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vt[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[8] = '{16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vt[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_sum",   64'(out_sum),   64'd0);
        chk("reset_out_cout",  64'(out_cout),  64'd0);
        chk("reset_out_ovf",   64'(out_ovf),   64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        rst    = 1'b0;
        rst_sw = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i], i);
        end

        // Backpressure: 8 back-to-back beats, consumer stalls cycles 6..8
        begin
            logic [33:0] q[$];
            int sent = 0;
            int got  = 0;
            for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
                @(negedge clk);
                out_ready = !(cyc >= 6 && cyc <= 8);
                if (sent < 8) begin
                    in_valid = 1'b1;
                    in_a     = 16'(sent * 16'h2345 + 16'h0F0F);
                    in_b     = 16'(sent * 16'h1357);
                    in_cin   = sent[0];
                    in_sub   = sent[1];
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (!out_ready) begin
                    chk($sformatf("bp_in_ready_c%0d", cyc), 64'(in_ready), 64'd0);
                    if (q.size() > 0) begin
                        chk($sformatf("bp_hold_c%0d", cyc), {out_ovf, out_cout, 32'(out_sum)}, q[0]);
                    end
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL bp_unexpected: got=0x%0h want=none", out_sum);
                    end else begin
                        chk($sformatf("bp_out%0d", got), {out_ovf, out_cout, 32'(out_sum)}, q.pop_front());
                    end
                    got++;
                end
                if (in_valid && in_ready) begin
                    q.push_back(model(16, 32'(in_a), 32'(in_b), in_cin, in_sub));
                    sent++;
                end
            end
            in_valid = 1'b0;
            chk("bp_count", 64'(got), 64'd8);
        end

        // Reset with 3 beats in flight and the output held
        begin
            int wt;
            int stale = 0;
            @(negedge clk);
            out_ready = 1'b0;
            in_a      = 16'h4321;
            in_b      = 16'h1111;
            in_cin    = 1'b0;
            in_sub    = 1'b0;
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                @(negedge clk);
            end
            in_valid = 1'b0;
            for (wt = 0; wt < 10 && !out_valid; wt++) @(negedge clk);
            chk("rst_pre_valid", 64'(out_valid), 64'd1);
            chk("rst_pre_sum",   64'(out_sum),   64'h5432);
            #2;
            rst = 1'b1;
            #1;
            chk("rst_async_valid", 64'(out_valid), 64'd0);
            chk("rst_async_sum",   64'(out_sum),   64'd0);
            repeat (2) @(negedge clk);
            rst       = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                #1;
                if (out_valid) stale++;
            end
            chk("rst_no_stale", 64'(stale), 64'd0);
            run_vec(vt[2], 100);
        end

        for (int i = 0; i < 5000 && sweeps_done < 3; i++) @(negedge clk);
        chk("sweeps_done", 64'(sweeps_done), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // --------------------------------------------------- parameter sweep DUTs
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W   = (g == 2) ? 32 : 8;
        localparam int S   = (g == 0) ? 1 : 8;
        localparam int LAT = (g == 0) ? 8 : ((g == 1) ? 1 : 4);
        localparam int N   = 60;

        logic         s_in_valid = 1'b0, s_in_ready, s_in_cin = 1'b0, s_in_sub = 1'b0;
        logic [W-1:0] s_in_a = '0, s_in_b = '0, s_out_sum;
        logic         s_out_valid, s_out_ready = 1'b1, s_out_cout, s_out_ovf;

        pipelined_segment_adder #(.WIDTH(W), .SEG_W(S)) u_dut (
            .clk       (clk),
            .rst       (rst_sw),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .in_a      (s_in_a),
            .in_b      (s_in_b),
            .in_cin    (s_in_cin),
            .in_sub    (s_in_sub),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .out_sum   (s_out_sum),
            .out_cout  (s_out_cout),
            .out_ovf   (s_out_ovf)
        );

        initial begin
            logic [33:0] q[$];
            int   sent  = 0;
            int   got   = 0;
            int   lat;
            logic fired = 1'b0;

            @(negedge clk);
            while (rst_sw) @(negedge clk);

            // Latency probe with a single beat
            @(negedge clk);
            s_in_a      = W'($urandom);
            s_in_b      = W'($urandom);
            s_in_cin    = 1'b1;
            s_in_sub    = 1'b1;
            s_in_valid  = 1'b1;
            s_out_ready = 1'b1;
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
            lat        = 1;
            while (!s_out_valid && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("sw%0d_latency", g), 64'(lat), 64'(LAT));
            chk($sformatf("sw%0d_probe", g), {s_out_ovf, s_out_cout, 32'(s_out_sum)},
                model(W, 32'(s_in_a), 32'(s_in_b), s_in_cin, s_in_sub));
            @(posedge clk);
            #1;

            // Random stream with random consumer backpressure
            for (int cyc = 0; cyc < 3000 && got < N; cyc++) begin
                @(negedge clk);
                s_out_ready = ($urandom_range(3) != 0);
                if (!s_in_valid || fired) begin
                    s_in_valid = (sent < N) && ($urandom_range(3) != 0);
                    s_in_a     = W'($urandom);
                    s_in_b     = W'($urandom);
                    s_in_cin   = 1'($urandom_range(1));
                    s_in_sub   = 1'($urandom_range(1));
                end
                #1;
                fired = s_in_valid && s_in_ready;
                if (s_out_valid && s_out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sw%0d_unexpected: got=0x%0h want=none", g, s_out_sum);
                    end else begin
                        chk($sformatf("sw%0d_out%0d", g, got),
                            {s_out_ovf, s_out_cout, 32'(s_out_sum)}, q.pop_front());
                    end
                    got++;
                end
                if (fired) begin
                    q.push_back(model(W, 32'(s_in_a), 32'(s_in_b), s_in_cin, s_in_sub));
                    sent++;
                end
            end
            s_in_valid = 1'b0;
            chk($sformatf("sw%0d_count", g), 64'(got), 64'(N));
            sweeps_done++;
        end
    end

endmodule : tb_pipelined_segment_adder
`default_nettype wire
